// File: rtl/gf_log4.sv
// gf_log4: sequential discrete logarithm over GF(2^m), m = 2..MAXM.
// It accepts an element in polynomial form together with m and prim_poly,
// steps alpha^k with an LFSR until alpha^k equals the element, and returns k.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous reset, active low
//   m          field degree (legal 2..MAXM), sampled on accept
//   prim_poly  primitive polynomial, bit i = coefficient of x^i, sampled on accept
//   a          element to convert, sampled on accept
//   in_valid   request present
//   in_ready   high only while idle
//   exponent   k such that alpha^k == a
//   err_code   00 ok, 01 zero operand, 10 bad config, 11 not found
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
module gf_log4 #(
  parameter int unsigned MAXM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      m,
  input  logic [MAXM:0]   prim_poly,
  input  logic [MAXM-1:0] a,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [MAXM-1:0] exponent,
  output logic [1:0]      err_code,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int unsigned PW = MAXM + 1;
  localparam logic [2:0] MaxM = 3'(MAXM);

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrZero     = 2'b01;
  localparam logic [1:0] ErrConfig   = 2'b10;
  localparam logic [1:0] ErrNotFound = 2'b11;

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      m_q, m_d;
  logic [PW-1:0]   poly_q, poly_d;
  logic [MAXM-1:0] a_q, a_d;
  logic [MAXM-1:0] cur_q, cur_d;
  logic [MAXM-1:0] k_q, k_d;
  logic [MAXM-1:0] exp_q, exp_d;
  logic [1:0]      err_q, err_d;

  // Request validation, evaluated on the raw inputs in the accept cycle.
  logic [PW-1:0] in_mask;
  logic [PW-1:0] poly_sh;
  logic          cfg_bad;
  logic          a_bad;

  assign in_mask = (PW'(1) << m) - PW'(1);
  assign poly_sh = prim_poly >> m;
  // poly_sh[0] is the x^m coefficient; anything left above it is a stray term.
  assign cfg_bad = (m < 3'd2) || (m > MaxM) || !poly_sh[0] || !prim_poly[0] ||
                   ((poly_sh >> 1) != '0);
  assign a_bad   = (a & ~in_mask[MAXM-1:0]) != '0;

  // LFSR step on the latched configuration: cur * x mod prim_poly.
  logic [PW-1:0]   mask_q;
  logic [PW-1:0]   shifted;
  logic [PW-1:0]   top_sh;
  logic [PW-1:0]   reduced;
  logic [MAXM-1:0] cur_next;
  logic [MAXM-1:0] last_k;

  assign mask_q   = (PW'(1) << m_q) - PW'(1);
  assign shifted  = {cur_q, 1'b0};
  assign top_sh   = shifted >> m_q;
  assign reduced  = top_sh[0] ? (shifted ^ poly_q) : shifted;
  assign cur_next = reduced[MAXM-1:0] & mask_q[MAXM-1:0];
  // n - 1 where n = 2^m - 1 is the multiplicative group order.
  assign last_k   = mask_q[MAXM-1:0] - MAXM'(1);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    poly_d  = poly_q;
    a_d     = a_q;
    cur_d   = cur_q;
    k_d     = k_q;
    exp_d   = exp_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          m_d    = m;
          poly_d = prim_poly;
          a_d    = a;
          if (cfg_bad || a_bad) begin
            state_d = StDone;
            exp_d   = '0;
            err_d   = ErrConfig;
          end else if (a == '0) begin
            state_d = StDone;
            exp_d   = '0;
            err_d   = ErrZero;
          end else begin
            state_d = StSearch;
            cur_d   = MAXM'(1);
            k_d     = '0;
          end
        end
      end
      StSearch: begin
        if (cur_q == a_q) begin
          state_d = StDone;
          exp_d   = k_q;
          err_d   = ErrOk;
        end else if (k_q == last_k) begin
          // The cycle of alpha closed without a hit: poly is not primitive.
          state_d = StDone;
          exp_d   = '0;
          err_d   = ErrNotFound;
        end else begin
          cur_d = cur_next;
          k_d   = k_q + MAXM'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      m_q     <= '0;
      poly_q  <= '0;
      a_q     <= '0;
      cur_q   <= '0;
      k_q     <= '0;
      exp_q   <= '0;
      err_q   <= ErrOk;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      poly_q  <= poly_d;
      a_q     <= a_d;
      cur_q   <= cur_d;
      k_q     <= k_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign exponent  = exp_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_gf_log4.sv
// Testbench for gf_log4: directed cases, handshake/hold behaviour, reset
// priority and randomized requests checked against a polynomial-division model.
module tb_gf_log4;

  logic       clk;
  logic       rst_n;
  logic [2:0] m;
  logic [4:0] prim_poly;
  logic [3:0] a;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] exponent;
  logic [1:0] err_code;
  logic       out_valid;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  gf_log4 #(.MAXM(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m         (m),
    .prim_poly (prim_poly),
    .a         (a),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exponent  (exponent),
    .err_code  (err_code),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of polynomial d divided by polynomial p of degree mm.
  function automatic int polymod(input int d, input int p, input int mm);
    int r;
    r = d;
    for (int b = 24; b >= mm; b--) begin
      if (((r >> b) & 1) != 0) r = r ^ (p << (b - mm));
    end
    return r;
  endfunction

  // Expected exponent, error code and latency (edges after the accept edge).
  function automatic void model(input int mm, input int pp, input int aa,
                                output int e, output int er, output int lat);
    int n;
    e = 0;
    er = 2;
    lat = 0;
    if (mm < 2 || mm > 4) return;
    if (((pp >> mm) & 1) == 0 || (pp & 1) == 0 || (pp >> (mm + 1)) != 0) return;
    if ((aa >> mm) != 0) return;
    if (aa == 0) begin
      er = 1;
      return;
    end
    n = (1 << mm) - 1;
    er = 3;
    lat = n;
    for (int k = 0; k < n; k++) begin
      if (polymod(1 << k, pp, mm) == aa) begin
        e = k;
        er = 0;
        lat = k + 1;
        return;
      end
    end
  endfunction

  // Issue one request, check result and latency, hold for `hold` cycles, release.
  task automatic run_req(input logic [2:0] mm, input logic [4:0] pp, input logic [3:0] aa,
                         input int hold, input string nm);
    int e, er, lat, w, got_lat;
    model(int'(mm), int'(pp), int'(aa), e, er, lat);
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready wait: got %b want 1", nm, in_ready);
    end
    m = mm; prim_poly = pp; a = aa; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the latched copies must be used.
    in_valid = 1'b0;
    m = 3'($urandom); prim_poly = 5'($urandom); a = 4'($urandom);
    got_lat = 0;
    while (!out_valid && got_lat < 40) begin
      @(posedge clk); #1; got_lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid timeout: got %b want 1", nm, out_valid);
    end else begin
      checks++;
      if (exponent !== 4'(e)) begin
        errors++;
        $display("FAIL %s exponent: got %0d want %0d (m=%0d poly=%b a=%b)",
                 nm, exponent, e, mm, pp, aa);
      end
      checks++;
      if (err_code !== 2'(er)) begin
        errors++;
        $display("FAIL %s err_code: got %b want %b (m=%0d poly=%b a=%b)",
                 nm, err_code, 2'(er), mm, pp, aa);
      end
      checks++;
      if (got_lat != lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", nm, got_lat, lat);
      end
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1;
        m = 3'($urandom); prim_poly = 5'($urandom); a = 4'($urandom);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || exponent !== 4'(e) ||
            err_code !== 2'(er)) begin
          errors++;
          $display("FAIL %s hold %0d: got v=%b r=%b e=%0d er=%b want v=1 r=0 e=%0d er=%b",
                   nm, h, out_valid, in_ready, exponent, err_code, e, 2'(er));
        end
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got v=%b r=%b want v=0 r=1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; m = 3'd3; prim_poly = 5'b01011; a = 4'b0011; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exponent !== 4'd0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b e=%0d er=%b want v=0 r=1 e=0 er=00",
               out_valid, in_ready, exponent, err_code);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_req(3'd3, 5'b01011, 4'b0011, 0, "m3_a3");
    run_req(3'd3, 5'b01011, 4'b0101, 0, "m3_last");
    run_req(3'd4, 5'b10011, 4'b1001, 0, "m4_a9");
    run_req(3'd4, 5'b10011, 4'b0001, 0, "m4_one");
    run_req(3'd3, 5'b10000, 4'b0011, 0, "bad_poly");
    run_req(3'd3, 5'b01011, 4'b0000, 0, "zero");
    run_req(3'd3, 5'b01011, 4'b1000, 0, "a_wide");
    run_req(3'd1, 5'b00011, 4'b0001, 0, "m_small");
    run_req(3'd5, 5'b10011, 4'b0001, 0, "m_big");
    run_req(3'd3, 5'b11011, 4'b0001, 0, "poly_high");
    run_req(3'd4, 5'b10101, 4'b0011, 0, "nonprim_miss");
    run_req(3'd4, 5'b10101, 4'b0101, 0, "nonprim_hit");
  endtask

  task automatic test_hold();
    run_req(3'd3, 5'b01011, 4'b0011, 5, "hold5");
  endtask

  task automatic test_back_to_back();
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    m = 3'd3; prim_poly = 5'b10000; a = 4'b0001; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || err_code !== 2'b10) begin
      errors++;
      $display("FAIL b2b first: got v=%b er=%b want v=1 er=10", out_valid, err_code);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle gap: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b second: got v=%b r=%b want v=1 r=0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_search();
    run_req(3'd3, 5'b01011, 4'b0101, 0, "pre_reset");
    m = 3'd4; prim_poly = 5'b10011; a = 4'b1001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || exponent !== 4'd6) begin
      errors++;
      $display("FAIL search hold: got v=%b r=%b e=%0d want v=0 r=0 e=6",
               out_valid, in_ready, exponent);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exponent !== 4'd0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL mid reset: got v=%b r=%b e=%0d er=%b want v=0 r=1 e=0 er=00",
               out_valid, in_ready, exponent, err_code);
    end
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL discarded: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [4:0] prims [0:4];
    logic [2:0] mm;
    logic [4:0] pp;
    logic [3:0] aa;
    prims[0] = 5'b00111; prims[1] = 5'b01011; prims[2] = 5'b01101;
    prims[3] = 5'b10011; prims[4] = 5'b11001;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) != 0) mm = 3'($urandom_range(2, 4));
      else mm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) pp = 5'($urandom);
      else if (mm == 3'd2) pp = prims[0];
      else if (mm == 3'd3) pp = prims[$urandom_range(1, 2)];
      else pp = prims[$urandom_range(3, 4)];
      aa = 4'($urandom);
      if ($urandom_range(0, 5) != 0 && mm >= 3'd2 && mm <= 3'd4)
        aa = aa & 4'((1 << mm) - 1);
      run_req(mm, pp, aa, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    m = '0;
    prim_poly = '0;
    a = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_mid_search();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
